serialize: RTL and testbench
============================

# serialize

Width-down converter on the transmit path: accepts one `8*WORD_BYTES`-bit word per handshake and emits it one byte per handshake toward the UART transmitter. It is the counterpart of `replicate`, closing the loop from the wide processor result back to the 8-bit `uart_controller` transmit interface. It sits between the processor output and `transmit_data`/`transmit_valid`/`transmit_ready`. A one-word holding register lets the next word be accepted while the current one is still being sent.

## Interface
- `WORD_BYTES`, 52: bytes per input word; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = send `in_data[8*WORD_BYTES-1 -: 8]` first; 0 = send `in_data[7:0]` first.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8*WORD_BYTES  input word; sampled only on an input handshake.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  block can take a word.
- `out_data`  out  8  current byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream takes the byte.
- `out_last`  out  1  current byte is byte `WORD_BYTES-1` of its word.

## Operation
- State:
  - shift slot: word register, byte index `idx` (0..WORD_BYTES-1), `busy` flag;
  - hold slot: word register, `hold_valid` flag.
- Handshakes:
  - input handshake = `in_valid && in_ready`;
  - output handshake = `out_valid && out_ready`.
- `in_ready = !hold_valid`. It is forced 0 while `reset` is low, and never depends combinationally on `out_ready`.
- `out_valid = busy`. `out_last = busy && idx == WORD_BYTES-1`.
- `out_data` is byte `idx` of the shift word, in the order set by `MSB_FIRST`.
- Input handshake routing:
  - not busy: word loads into the shift slot, `idx` ← 0, `busy` ← 1;
  - busy, and last byte not leaving this cycle: word loads into the hold slot, `hold_valid` ← 1;
  - busy, last byte leaving this cycle, hold empty: word loads directly into the shift slot, `idx` ← 0, and the hold slot stays empty.
- Output handshake, not last byte: `idx` ← `idx`+1.
- Output handshake, last byte:
  - hold valid: hold word moves to the shift slot, `idx` ← 0, `hold_valid` ← 0. No bubble cycle.
  - hold empty and no simultaneous input handshake: `busy` ← 0.
- Effective states: EMPTY (!busy, !hold_valid), SENDING (busy, !hold_valid), FULL (busy, hold_valid). `!busy && hold_valid` is unreachable.
- `idx` saturates at `WORD_BYTES-1` and never wraps past it. The increment width is `$clog2(WORD_BYTES)`.
- Reset mid-word: the partial word and any held word are discarded. After reset is released, output restarts with a fresh word; there is no resume.

## Timing
- Reset values: `out_valid` 0, `out_last` 0, `out_data` 0, `busy` 0, `hold_valid` 0, `idx` 0. `in_ready` is 0 during reset and 1 from the first cycle after release.
- Latency: input handshake in cycle t (while EMPTY) → `out_valid`=1 with byte 0 in cycle t+1.
- Throughput: with `out_ready` held at 1, one byte per cycle sustained across word boundaries, provided upstream refills the hold slot within `WORD_BYTES-1` cycles.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- `in_ready` deasserts the cycle after the hold slot fills. It reasserts the cycle after the hold word moves to the shift slot.

## Structure
- Shared package `serialize_pkg`:
  - `BYTE_WIDTH` = 8;
  - function returning the index width, `$clog2(WORD_BYTES)` with a minimum of 1.
- One natural sub-module: `byte_word_register`. It holds a word plus valid flag, has a load-enable, and is instantiated twice (shift and hold). Byte selection and `idx` control stay in `serialize`.

## Test plan
Benches use `WORD_BYTES`=4.
- Reset value check: with `reset` low, `out_valid`=0, `out_data`=0, `in_ready`=0. One cycle after release, `in_ready`=1.
- Single word, `MSB_FIRST`=1, `out_ready`=1: input 0xA1B2C3D4 in cycle 0 → bytes A1, B2, C3, D4 in cycles 1–4, with `out_last` only on D4. `out_valid`=0 in cycle 5.
- `MSB_FIRST`=0, same word → D4, C3, B2, A1.
- Back-to-back words 0x01020304 then 0x05060708, `in_valid` constant, `out_ready`=1 → 8 consecutive bytes 01…08 with no gap. `in_ready` drops for the cycles the hold slot is full.
- Backpressure: `out_ready`=0 for 5 cycles during byte B2 → B2 held stable with `out_valid`=1. Third word offered while FULL: not accepted until the hold slot empties. No byte lost or duplicated.
- Reset asserted after 2 bytes of 0x11223344 with 0x55667788 held → after release `out_valid`=0 and `in_ready`=1. New word 0x99AABBCC is emitted starting at 99, and no 33/44/55 bytes appear.

Source files
------------

// File: rtl/serialize_pkg.sv
// rtl/serialize_pkg.sv - shared constants and helpers for the serialize block
package serialize_pkg;

  localparam int BYTE_WIDTH = 8;

  // Width of the byte index for a word of word_bytes bytes, never narrower than one bit
  function automatic int idx_width(input int word_bytes);
    int w;
    w = $clog2(word_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serialize_if.sv
// rtl/serialize_if.sv - word-in / byte-out handshake bundle for serialize
interface serialize_if
  import serialize_pkg::*;
#(
  parameter int WORD_BYTES = 52
) ();

  logic [BYTE_WIDTH*WORD_BYTES-1:0] in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic [BYTE_WIDTH-1:0]            out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_last;

  // Producer of words and consumer of bytes
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

  // The width-down converter itself
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

endinterface

// File: rtl/serialize_byte_word_register.sv
// rtl/serialize_byte_word_register.sv - word register with load enable and valid flag
module byte_word_register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             valid_d,
  output logic [WIDTH-1:0] word_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] word_d;

  // Take a new word only when load is asserted, otherwise keep the current one
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = load_word;
    end
  end

  // Word and valid flag; reset discards whatever was stored
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/serialize.sv
// rtl/serialize.sv - wide word to byte stream converter with one-word holding slot
module serialize
  import serialize_pkg::*;
#(
  parameter int WORD_BYTES = 52,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic       clock,
  input logic       reset,
  serialize_if.slave bus
);

  localparam int                   WORD_WIDTH = BYTE_WIDTH * WORD_BYTES;
  localparam int                   IDX_WIDTH  = idx_width(WORD_BYTES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(WORD_BYTES - 1);

  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  idx_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  hold_valid_q;
  logic                  hold_valid_d;

  logic                  shift_load;
  logic                  hold_load;
  logic [WORD_WIDTH-1:0] shift_load_word;
  logic [WORD_WIDTH-1:0] shift_word_q;
  logic [WORD_WIDTH-1:0] hold_word_q;

  logic                  in_ready_w;
  logic                  in_hs;
  logic                  out_hs;
  logic                  at_last;
  logic                  last_leaving;

  logic [IDX_WIDTH-1:0]                   byte_sel;
  logic [WORD_BYTES-1:0][BYTE_WIDTH-1:0]  shift_bytes;

  // Ready depends only on the hold slot, so it never follows out_ready combinationally
  assign in_ready_w   = reset & ~hold_valid_q;
  assign in_hs        = bus.in_valid & in_ready_w;
  assign out_hs       = busy_q & bus.out_ready;
  assign at_last      = (idx_q == LAST_IDX);
  assign last_leaving = out_hs & at_last;

  // Next-state routing of words between input, hold slot and shift slot
  always_comb begin
    idx_d           = idx_q;
    busy_d          = busy_q;
    hold_valid_d    = hold_valid_q;
    shift_load      = 1'b0;
    hold_load       = 1'b0;
    shift_load_word = bus.in_data;

    if (out_hs) begin
      if (!at_last) begin
        // idx stops at the last byte; it only advances below it
        idx_d = idx_q + IDX_WIDTH'(1);
      end else if (hold_valid_q) begin
        // Held word takes over in the same cycle, so the byte stream has no gap
        shift_load      = 1'b1;
        shift_load_word = hold_word_q;
        idx_d           = '0;
        hold_valid_d    = 1'b0;
      end else begin
        busy_d = 1'b0;
      end
    end

    // in_hs implies the hold slot is empty, so it never collides with the hold-to-shift move
    if (in_hs) begin
      if (!busy_q || last_leaving) begin
        // Idle, or the shift slot frees up this cycle: bypass the hold slot
        shift_load      = 1'b1;
        shift_load_word = bus.in_data;
        idx_d           = '0;
        busy_d          = 1'b1;
      end else begin
        hold_load    = 1'b1;
        hold_valid_d = 1'b1;
      end
    end
  end

  // Byte index; cleared by reset so a new word always starts at byte 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  byte_word_register #(
    .WIDTH(WORD_WIDTH)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .load     (shift_load),
    .load_word(shift_load_word),
    .valid_d  (busy_d),
    .word_q   (shift_word_q),
    .valid_q  (busy_q)
  );

  byte_word_register #(
    .WIDTH(WORD_WIDTH)
  ) u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (hold_load),
    .load_word(bus.in_data),
    .valid_d  (hold_valid_d),
    .word_q   (hold_word_q),
    .valid_q  (hold_valid_q)
  );

  // Byte order: MSB_FIRST walks the word from its top byte downward
  always_comb begin
    shift_bytes = shift_word_q;
    byte_sel    = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = busy_q;
  assign bus.out_last  = busy_q & at_last;
  assign bus.out_data  = shift_bytes[byte_sel];

endmodule

// File: tb/tb_serialize.sv
// tb/tb_serialize.sv - directed bench for serialize, both byte orders side by side
module tb_serialize;

  localparam int WB = 4;

  logic          clock;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          out_ready;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: queue of accepted words plus position inside the front word
  logic [31:0] wq[$];
  int          pos = 0;

  logic [7:0]  cap_a[$];
  logic [7:0]  cap_b[$];
  int          cap_cyc[$];

  logic [7:0] one_a [4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] one_b [4]  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0] b2b_b [8]  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
  logic [7:0] bp_a  [12] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                             8'h0E, 8'h0F, 8'h10, 8'h11};
  logic [7:0] bp_b  [12] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h0D, 8'h0C, 8'h0B, 8'h0A,
                             8'h11, 8'h10, 8'h0F, 8'h0E};
  logic [7:0] rs_a  [6]  = '{8'h11, 8'h22, 8'h99, 8'hAA, 8'hBB, 8'hCC};
  logic [7:0] rs_b  [6]  = '{8'h44, 8'h33, 8'hCC, 8'hBB, 8'hAA, 8'h99};

  serialize_if #(.WORD_BYTES(WB)) ia ();
  serialize_if #(.WORD_BYTES(WB)) ib ();

  assign ia.in_data   = in_data;
  assign ia.in_valid  = in_valid;
  assign ia.out_ready = out_ready;
  assign ib.in_data   = in_data;
  assign ib.in_valid  = in_valid;
  assign ib.out_ready = out_ready;

  serialize #(.WORD_BYTES(WB), .MSB_FIRST(1'b1)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (ia.slave)
  );

  serialize #(.WORD_BYTES(WB), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (ib.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: compare both DUTs with the model, then apply this cycle's handshakes
  initial begin
    int          pending;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        wq.delete();
        pos = 0;
        check("rst a out_valid", 32'(ia.out_valid), 32'd0);
        check("rst b out_valid", 32'(ib.out_valid), 32'd0);
        check("rst a out_last",  32'(ia.out_last),  32'd0);
        check("rst a out_data",  32'(ia.out_data),  32'd0);
        check("rst b out_data",  32'(ib.out_data),  32'd0);
        check("rst a in_ready",  32'(ia.in_ready),  32'd0);
        check("rst b in_ready",  32'(ib.in_ready),  32'd0);
      end else begin
        pending   = wq.size() * WB - pos;
        exp_valid = (pending > 0);
        exp_ready = (pending <= WB);
        check("a out_valid", 32'(ia.out_valid), 32'(exp_valid));
        check("b out_valid", 32'(ib.out_valid), 32'(exp_valid));
        check("a in_ready",  32'(ia.in_ready),  32'(exp_ready));
        check("b in_ready",  32'(ib.in_ready),  32'(exp_ready));
        if (exp_valid) begin
          w = wq[0];
          check("a out_data", 32'(ia.out_data), 32'(8'(w >> ((WB - 1 - pos) * 8))));
          check("b out_data", 32'(ib.out_data), 32'(8'(w >> (pos * 8))));
          check("a out_last", 32'(ia.out_last), 32'(pos == WB - 1));
          check("b out_last", 32'(ib.out_last), 32'(pos == WB - 1));
          if (out_ready) begin
            cap_a.push_back(ia.out_data);
            cap_b.push_back(ib.out_data);
            cap_cyc.push_back(cyc);
            pos++;
            if (pos == WB) begin
              void'(wq.pop_front());
              pos = 0;
            end
          end
        end
        if (in_valid && exp_ready) begin
          wq.push_back(in_data);
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_b.delete();
    cap_cyc.delete();
  endtask

  // Offer a word until it is taken, bounded
  task automatic send_word(input logic [31:0] w);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (ia.in_ready) ok = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    check("send accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (!ia.out_valid && !ib.out_valid && ia.in_ready) done = 1'b1;
      next_cycle();
    end
    check("drain", 32'(done), 32'd1);
  endtask

  initial begin
    int low;
    int iters;
    logic ok;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clock);
    check("reset in_ready",  32'(ia.in_ready),  32'd0);
    check("reset out_valid", 32'(ia.out_valid), 32'd0);
    check("reset out_data",  32'(ia.out_data),  32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("release in_ready", 32'(ia.in_ready), 32'd1);
    next_cycle();

    // Single word, cycle-exact
    clear_caps();
    send_word(32'hA1B2C3D4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("one a valid", 32'(ia.out_valid), 32'd1);
      check("one a data",  32'(ia.out_data),  32'(one_a[k]));
      check("one b data",  32'(ib.out_data),  32'(one_b[k]));
      check("one a last",  32'(ia.out_last),  32'(k == 3));
      check("one b last",  32'(ib.out_last),  32'(k == 3));
      next_cycle();
    end
    @(negedge clock);
    check("one a idle", 32'(ia.out_valid), 32'd0);
    check("one b idle", 32'(ib.out_valid), 32'd0);
    next_cycle();

    // Back-to-back words, no gap in the byte stream
    clear_caps();
    send_word(32'h01020304);
    send_word(32'h05060708);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!ia.in_ready) low++;
      next_cycle();
    end
    check("b2b hold full cycles", 32'(low), 32'd3);
    wait_drain();
    check("b2b count", 32'(cap_a.size()), 32'd8);
    if (cap_a.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("b2b a byte", 32'(cap_a[i]), 32'(i + 1));
        check("b2b b byte", 32'(cap_b[i]), 32'(b2b_b[i]));
      end
      check("b2b span", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);
    end

    // Backpressure on the second byte with a third word waiting
    clear_caps();
    send_word(32'hA1B2C3D4);
    in_valid = 1'b1;
    in_data  = 32'h0A0B0C0D;
    next_cycle();
    in_data   = 32'h0E0F1011;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp a stall valid", 32'(ia.out_valid), 32'd1);
      check("bp a stall data",  32'(ia.out_data),  32'hB2);
      check("bp b stall data",  32'(ib.out_data),  32'hC3);
      check("bp stall in_ready", 32'(ia.in_ready), 32'd0);
      next_cycle();
    end
    out_ready = 1'b1;
    ok    = 1'b0;
    iters = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      iters++;
      if (ia.in_ready) ok = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    check("bp third accept wait", 32'(iters), 32'd4);
    wait_drain();
    check("bp count", 32'(cap_a.size()), 32'd12);
    if (cap_a.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check("bp a byte", 32'(cap_a[i]), 32'(bp_a[i]));
        check("bp b byte", 32'(cap_b[i]), 32'(bp_b[i]));
      end
    end

    // Reset in the middle of a word with a held word pending
    clear_caps();
    send_word(32'h11223344);
    in_valid = 1'b1;
    in_data  = 32'h55667788;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("midrst out_valid", 32'(ia.out_valid), 32'd0);
    check("midrst in_ready",  32'(ia.in_ready),  32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("post rst out_valid", 32'(ia.out_valid), 32'd0);
    check("post rst in_ready",  32'(ia.in_ready),  32'd1);
    next_cycle();
    send_word(32'h99AABBCC);
    wait_drain();
    check("rst count", 32'(cap_a.size()), 32'd6);
    if (cap_a.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("rst a byte", 32'(cap_a[i]), 32'(rs_a[i]));
        check("rst b byte", 32'(cap_b[i]), 32'(rs_b[i]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
